// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive and transmit sides.
//   - uart_state_e : receiver FSM state encoding
//   - DataWDefault : default number of data bits per frame
//   - ParityEn     : 1 when built with UART_RX_PARITY_EN (8E1), else 0 (8N1)
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StWaitIdle
    } uart_state_e;

    localparam int unsigned DataWDefault = 8;

`ifdef UART_RX_PARITY_EN
    localparam bit ParityEn = 1'b1;
`else
    localparam bit ParityEn = 1'b0;
`endif

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the asynchronous serial line.
// Both flops reset to 1 so a line held idle-high never looks like a start bit.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   rx_i  - raw asynchronous serial input
//   rx_o  - synchronized serial line
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_i,
    output logic rx_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= rx_i;
            sync_q <= meta_q;
        end
    end

    assign rx_o = sync_q;

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: UART receiver (LSB first, idle high) with a one-entry held
// output register and valid/ready handshake.
// Build option: define UART_RX_PARITY_EN for 8E1 frames (even parity checked,
// parity_err live); otherwise frames are 8N1 and parity_err is constant 0.
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   rx         - asynchronous serial line
//   data       - received byte, stable while valid
//   valid      - data holds an unconsumed byte
//   ready      - consumer accepts data when valid && ready
//   frame_err  - 1-cycle pulse: stop bit sampled low
//   parity_err - 1-cycle pulse: parity mismatch
//   overrun    - 1-cycle pulse: byte dropped because data was still held
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned DATA_W       = DataWDefault
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    input  logic              ready,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overrun
);

    localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BitW  = $clog2(DATA_W + 1);
    // The counter counts down to zero and the sample takes one more cycle,
    // so load one less than the wanted interval.
    localparam logic [BaudW-1:0] BaudFull = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [BaudW-1:0] BaudHalf = BaudW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_W - 1);

    logic rx_s;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .rx_i  (rx),
        .rx_o  (rx_s)
    );

    uart_state_e       state_q, state_d;
    logic [BaudW-1:0]  baud_q, baud_d;
    logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              frame_err_q, frame_err_d;
    logic              parity_err_q, parity_err_d;
    logic              overrun_q, overrun_d;
    logic              baud_tick;
    logic              par_bad;

`ifdef UART_RX_PARITY_EN
    logic par_bad_q, par_bad_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bad_q <= 1'b0;
        end else begin
            par_bad_q <= par_bad_d;
        end
    end

    assign par_bad = par_bad_q;
`else
    assign par_bad = 1'b0;
`endif

    assign baud_tick = (baud_q == '0);

    always_comb begin
        state_d      = state_q;
        baud_d       = baud_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        data_d       = data_q;
        valid_d      = valid_q;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        overrun_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
`endif

        // A newly delivered byte below overrides this clear.
        if (valid_q && ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (!rx_s) begin
                    bit_cnt_d = '0;
                    baud_d    = BaudHalf;
                    state_d   = StStart;
                end
            end
            StStart: begin
                if (!baud_tick) begin
                    baud_d = baud_q - BaudW'(1);
                end else if (rx_s) begin
                    state_d = StIdle;
                end else begin
                    baud_d  = BaudFull;
                    state_d = StData;
                end
            end
            StData: begin
                if (!baud_tick) begin
                    baud_d = baud_q - BaudW'(1);
                end else begin
                    baud_d  = BaudFull;
                    shift_d = {rx_s, shift_q[DATA_W-1:1]};
                    if (bit_cnt_q == BitLast) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BitW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (!baud_tick) begin
                    baud_d = baud_q - BaudW'(1);
                end else begin
                    baud_d    = BaudFull;
                    par_bad_d = rx_s ^ (^shift_q);
                    state_d   = StStop;
                end
            end
`endif
            StStop: begin
                if (!baud_tick) begin
                    baud_d = baud_q - BaudW'(1);
                end else if (!rx_s) begin
                    frame_err_d  = 1'b1;
                    parity_err_d = par_bad;
                    state_d      = StWaitIdle;
                end else if (par_bad) begin
                    parity_err_d = 1'b1;
                    state_d      = StIdle;
                end else begin
                    state_d = StIdle;
                    if (!valid_q || ready) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end
            StWaitIdle: begin
                // Hold off until the line returns high so a break is one error.
                if (rx_s) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            baud_q       <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            baud_q       <= baud_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = ParityEn & parity_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Testbench for uart_rx_core with CLKS_PER_BIT=16. Table of frames plus
// hand-written sequences for glitch, overrun and mid-frame reset.
module tb_uart_rx_core;
    import uart_pkg::*;

    localparam int unsigned Cpb = 16;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned Lat = 2 + Cpb / 2 + 10 * Cpb + 1;
`else
    localparam int unsigned Lat = 2 + Cpb / 2 + 9 * Cpb + 1;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;

    uart_rx_core #(
        .CLKS_PER_BIT (Cpb),
        .DATA_W       (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .data       (data),
        .valid      (valid),
        .ready      (ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampled on the falling edge.
    int unsigned vcnt = 0, fcnt = 0, pcnt = 0, ocnt = 0, vcyc = 0;
    logic [7:0]  vdata = 8'h00;
    logic        valid_prev = 1'b0;
    always @(negedge clk) begin
        if (valid && !valid_prev) begin
            vcnt  = vcnt + 1;
            vdata = data;
            vcyc  = cyc;
        end
        valid_prev = valid;
        if (frame_err)  fcnt = fcnt + 1;
        if (parity_err) pcnt = pcnt + 1;
        if (overrun)    ocnt = ocnt + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Caller is aligned 1 time unit after a rising edge.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic pflip,
                              output int unsigned fall_cyc);
        rx       = 1'b0;
        fall_cyc = cyc;
        wait_cyc(Cpb);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cyc(Cpb);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ pflip;
        wait_cyc(Cpb);
`else
        if (pflip) rx = 1'b1;
`endif
        rx = stop;
        wait_cyc(Cpb);
    endtask

    typedef struct {
        logic [7:0]  b;
        logic        stop;
        logic        pflip;
        int unsigned hold_low;
        logic        exp_v;
        logic [7:0]  exp_d;
        logic        exp_f;
        logic        exp_p;
    } vec_t;

    vec_t vecs[$];

    int unsigned v0, f0, p0, o0, fc;

    task automatic snap();
        v0 = vcnt; f0 = fcnt; p0 = pcnt; o0 = ocnt;
    endtask

    initial begin
        vecs.push_back('{8'hA5, 1'b1, 1'b0, 0,  1'b1, 8'hA5, 1'b0, 1'b0});
        vecs.push_back('{8'h3C, 1'b0, 1'b0, 40, 1'b0, 8'h00, 1'b1, 1'b0});
        vecs.push_back('{8'h81, 1'b1, 1'b0, 0,  1'b1, 8'h81, 1'b0, 1'b0});
        vecs.push_back('{8'h00, 1'b1, 1'b0, 0,  1'b1, 8'h00, 1'b0, 1'b0});
        vecs.push_back('{8'hFF, 1'b1, 1'b0, 0,  1'b1, 8'hFF, 1'b0, 1'b0});
        vecs.push_back('{8'h55, 1'b1, 1'b0, 0,  1'b1, 8'h55, 1'b0, 1'b0});
`ifdef UART_RX_PARITY_EN
        vecs.push_back('{8'h07, 1'b1, 1'b1, 0,  1'b0, 8'h00, 1'b0, 1'b1});
        vecs.push_back('{8'h07, 1'b1, 1'b0, 0,  1'b1, 8'h07, 1'b0, 1'b0});
        vecs.push_back('{8'h07, 1'b0, 1'b1, 20, 1'b0, 8'h00, 1'b1, 1'b1});
`endif

        // Reset state.
        wait_cyc(3);
        chk("rst_valid", {31'b0, valid}, 32'd0);
        chk("rst_data", {24'b0, data}, 32'd0);
        chk("rst_errs", {29'b0, frame_err, parity_err, overrun}, 32'd0);
        rst_n = 1'b1;
        wait_cyc(5);

        for (int i = 0; i < vecs.size(); i++) begin
            snap();
            send_frame(vecs[i].b, vecs[i].stop, vecs[i].pflip, fc);
            if (vecs[i].hold_low != 0) begin
                rx = 1'b0;
                wait_cyc(vecs[i].hold_low);
            end
            rx = 1'b1;
            wait_cyc(30);
            chk($sformatf("v%0d_valid_cnt", i), vcnt - v0, {31'b0, vecs[i].exp_v});
            if (vecs[i].exp_v) chk($sformatf("v%0d_data", i), {24'b0, vdata}, {24'b0, vecs[i].exp_d});
            chk($sformatf("v%0d_frame_err", i), fcnt - f0, {31'b0, vecs[i].exp_f});
            chk($sformatf("v%0d_parity_err", i), pcnt - p0, {31'b0, vecs[i].exp_p});
            chk($sformatf("v%0d_overrun", i), ocnt - o0, 32'd0);
            if (i == 0) chk("latency_a5", vcyc - fc, Lat);
        end

        // Short low glitch is a false start.
        snap();
        rx = 1'b0;
        wait_cyc(5);
        rx = 1'b1;
        wait_cyc(40);
        chk("glitch_valid", vcnt - v0, 32'd0);
        chk("glitch_errs", (fcnt - f0) + (pcnt - p0) + (ocnt - o0), 32'd0);
        chk("glitch_idle", 32'(dut.state_q), 32'(StIdle));

        // Overrun: two back-to-back frames with ready low.
        ready = 1'b0;
        snap();
        send_frame(8'h11, 1'b1, 1'b0, fc);
        send_frame(8'h22, 1'b1, 1'b0, fc);
        rx = 1'b1;
        wait_cyc(30);
        chk("ovr_valid_cnt", vcnt - v0, 32'd1);
        chk("ovr_data", {24'b0, data}, 32'h11);
        chk("ovr_valid", {31'b0, valid}, 32'd1);
        chk("ovr_pulse", ocnt - o0, 32'd1);
        ready = 1'b1;
        wait_cyc(1);
        chk("ovr_consume", {31'b0, valid}, 32'd0);

        // Mid-frame reset with a held byte pending.
        ready = 1'b0;
        send_frame(8'h5A, 1'b1, 1'b0, fc);
        rx = 1'b1;
        wait_cyc(20);
        chk("pre_rst_data", {24'b0, data}, 32'h5A);
        snap();
        rx = 1'b0;
        wait_cyc(Cpb);
        rx = 1'b1;
        wait_cyc(4 * Cpb + 8);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'b0, valid}, 32'd0);
        chk("midrst_data", {24'b0, data}, 32'd0);
        chk("midrst_errs", {29'b0, frame_err, parity_err, overrun}, 32'd0);
        wait_cyc(3);
        rst_n = 1'b1;
        ready = 1'b1;
        wait_cyc(200);
        chk("postrst_no_valid", vcnt - v0, 32'd0);
        chk("postrst_no_err", (fcnt - f0) + (pcnt - p0), 32'd0);
        snap();
        send_frame(8'h42, 1'b1, 1'b0, fc);
        rx = 1'b1;
        wait_cyc(30);
        chk("postrst_valid_cnt", vcnt - v0, 32'd1);
        chk("postrst_data", {24'b0, vdata}, 32'h42);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
